// File: rtl/adc_tdm_pkg.sv
// rtl/adc_tdm_pkg.sv - shared types and constants for the ADC TDM capture block
package adc_tdm_pkg;

   localparam int DEF_LANES       = 4;
   localparam int DEF_CH_PER_LANE = 2;
   localparam int DEF_SAMPLE_BITS = 24;
   localparam int DEF_IDX_W       = 32;
   localparam int DEF_CH_W        = 3;

   localparam int N_CH       = DEF_LANES * DEF_CH_PER_LANE;
   localparam int FRAME_BITS = DEF_SAMPLE_BITS * DEF_CH_PER_LANE;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } cap_state_e;

   typedef logic [DEF_CH_W-1:0] ch_t;

endpackage

// File: rtl/adc_sync_edge.sv
// rtl/adc_sync_edge.sv - two-flop synchroniser with a third flop for rise/fall detection
module adc_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[1:0], async_in};
      end
   end

   assign sync_out = sr[1];
   assign rise     = sr[1] & ~sr[2];
   assign fall     = ~sr[1] & sr[2];

endmodule

// File: rtl/adc_tdm_capture.sv
// rtl/adc_tdm_capture.sv - ADC multi-lane TDM deserialiser with Avalon-ST sample output
// Frames are shifted in per lane, parked in a holding bank, then streamed one channel per beat.
module adc_tdm_capture
   import adc_tdm_pkg::*;
#(
   parameter int LANES       = DEF_LANES,
   parameter int CH_PER_LANE = DEF_CH_PER_LANE,
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int CH_W        = DEF_CH_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   adc_dclk,
   input  logic [LANES-1:0]       adc_dout,
   input  logic                   adc_drdy_n,
   input  logic                   gps_1pps,
   output logic [SAMPLE_BITS-1:0] src_data,
   output logic [CH_W-1:0]        src_channel,
   output logic                   src_sop,
   output logic                   src_eop,
   output logic                   src_valid,
   input  logic                   src_ready,
   output logic [IDX_W-1:0]       frame_index,
   output logic                   overflow,
   output logic                   short_frame,
   input  logic                   clear_flags
);

   localparam int NCH   = LANES * CH_PER_LANE;
   localparam int FBITS = SAMPLE_BITS * CH_PER_LANE;
   localparam int BCW   = $clog2(FBITS);

   logic             dclk_s, dclk_rise, dclk_fall;
   logic             drdy_s, drdy_rise, drdy_fall;
   logic             pps_s, pps_rise, pps_fall;
   logic [LANES-1:0] dout_s, dout_rise, dout_fall;
   logic             unused_sync;

   adc_sync_edge u_sync_dclk (.clk(clk), .rst_n(reset_n), .async_in(adc_dclk),
                              .sync_out(dclk_s), .rise(dclk_rise), .fall(dclk_fall));
   adc_sync_edge u_sync_drdy (.clk(clk), .rst_n(reset_n), .async_in(adc_drdy_n),
                              .sync_out(drdy_s), .rise(drdy_rise), .fall(drdy_fall));
   adc_sync_edge u_sync_pps  (.clk(clk), .rst_n(reset_n), .async_in(gps_1pps),
                              .sync_out(pps_s), .rise(pps_rise), .fall(pps_fall));

   // DOUT shares the DCLK synchroniser depth, so dout_s is the bit present at dclk_rise.
   for (genvar l = 0; l < LANES; l++) begin : g_dout
      adc_sync_edge u_sync_dout (.clk(clk), .rst_n(reset_n), .async_in(adc_dout[l]),
                                 .sync_out(dout_s[l]), .rise(dout_rise[l]), .fall(dout_fall[l]));
   end

   assign unused_sync = &{dclk_s, dclk_fall, drdy_s, drdy_rise, pps_s, pps_fall, dout_rise, dout_fall};

   cap_state_e     state, state_nxt;
   logic [BCW-1:0] bit_cnt;
   logic           last_bit, clr_cnt, shift_en, restart, frame_done;

   assign last_bit = (bit_cnt == BCW'(FBITS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (drdy_fall) state_nxt = SHIFT;
         SHIFT:   if (!drdy_fall && dclk_rise && last_bit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clr_cnt    = 1'b0;
      shift_en   = 1'b0;
      restart    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: clr_cnt = drdy_fall;
         SHIFT: begin
            if (drdy_fall) begin
               clr_cnt = 1'b1;
               restart = 1'b1;
            end else if (dclk_rise) begin
               shift_en   = 1'b1;
               frame_done = last_bit;
            end
         end
         default: ;
      endcase
   end

   logic [FBITS-1:0] lane_sr  [LANES];
   logic [FBITS-1:0] lane_nxt [LANES];

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_nxt[l] = {lane_sr[l][FBITS-2:0], dout_s[l]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         for (int l = 0; l < LANES; l++) lane_sr[l] <= '0;
      end else begin
         if (clr_cnt) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (shift_en) begin
            for (int l = 0; l < LANES; l++) lane_sr[l] <= lane_nxt[l];
         end
      end
   end

   logic [SAMPLE_BITS-1:0] bank [NCH];
   logic [CH_W-1:0]        ch;
   logic [IDX_W-1:0]       idx_cnt, cap_idx;
   logic                   pps_pend, beat, last_beat, load;

   assign beat      = src_valid & src_ready;
   assign last_beat = beat && (ch == CH_W'(NCH - 1));
   // The bank is free either when idle or when its final beat leaves this same cycle.
   assign load      = frame_done && (!src_valid || last_beat);
   assign cap_idx   = (pps_rise || pps_pend) ? '0 : idx_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_valid   <= 1'b0;
         ch          <= '0;
         frame_index <= '0;
         for (int k = 0; k < NCH; k++) bank[k] <= '0;
      end else if (load) begin
         src_valid   <= 1'b1;
         ch          <= '0;
         frame_index <= cap_idx;
         for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < CH_PER_LANE; j++) begin
               bank[l*CH_PER_LANE + j] <= lane_nxt[l][FBITS-1-j*SAMPLE_BITS -: SAMPLE_BITS];
            end
         end
      end else if (last_beat) begin
         src_valid <= 1'b0;
         ch        <= '0;
      end else if (beat) begin
         ch <= ch + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_cnt     <= '0;
         pps_pend    <= 1'b0;
         overflow    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         if (frame_done) begin
            idx_cnt  <= cap_idx + 1'b1;
            pps_pend <= 1'b0;
         end else if (pps_rise) begin
            pps_pend <= 1'b1;
         end
         if (frame_done && !load) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
         if (restart) begin
            short_frame <= 1'b1;
         end else if (clear_flags) begin
            short_frame <= 1'b0;
         end
      end
   end

   assign src_data    = bank[ch];
   assign src_channel = ch;
   assign src_sop     = src_valid && (ch == '0);
   assign src_eop     = src_valid && (ch == CH_W'(NCH - 1));

endmodule
